fpmult_host: RTL and testbench

Initiator side of the FP multiplier operand/result protocol (startFP / shared 32-bit inBus / doneFP / resBus).
- Accepts single-precision operand pairs on a valid/ready stream and sequences start, A, then B onto the shared bus.
- Waits for completion, buffers the product and returns it on a valid/ready result stream.
- Includes a watchdog that reports a hung multiplier.

---
 rtl/fpmult_pkg.sv | 6 +
 rtl/fpmult_res_buf.sv | 28 ++
 rtl/fpmult_host.sv | 109 ++++++++++
 tb/tb_fpmult_host.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fpmult_pkg.sv
// fpmult_pkg: shared state encoding, quiet-NaN constant and default width for the FP multiplier host
package fpmult_pkg;
  localparam int DATA_W_DEF = 32;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  typedef enum logic [2:0] {IDLE, START, GAP, SEND_A, SEND_B, WAIT} state_t;
endpackage

// File: rtl/fpmult_res_buf.sv
// fpmult_res_buf: one-entry valid/ready register (clk,rst; i_load/i_data in; o_valid/o_data out; i_ready drains)
module fpmult_res_buf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data
);
  logic         r_valid;
  logic [W-1:0] r_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end
  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/fpmult_host.sv
// fpmult_host: sequences op pairs onto the multiplier bus (op_* in, fp_* to/from multiplier, res_* out, busy, ops_done, watchdog)
module fpmult_host
  import fpmult_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              fp_start,
  output logic [DATA_W-1:0] fp_bus,
  input  logic              fp_done,
  input  logic [DATA_W-1:0] fp_res,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_done
);
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  state_t            r_state;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_fp_bus;
  logic              r_fp_start;
  logic              r_seen_busy;
  logic [WD_W-1:0]   r_wd;
  logic [CNT_W-1:0]  r_ops;
  logic              w_fire;
  logic              w_done_ok;
  logic              w_timeout;
  logic              w_load;
  logic [DATA_W:0]   w_res;
  logic [DATA_W:0]   w_buf;
  assign op_ready  = (r_state == IDLE) && fp_done && !res_valid;
  assign w_fire    = op_valid && op_ready;
  assign w_done_ok = (r_state == WAIT) && fp_done && r_seen_busy;
  assign w_timeout = (r_state == WAIT) && (r_wd == WD_W'(TIMEOUT - 1));
  assign w_load    = w_done_ok || w_timeout;
  assign w_res     = w_done_ok ? {1'b0, fp_res} : {1'b1, DATA_W'(QNAN)};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_fp_bus    <= '0;
      r_fp_start  <= 1'b0;
      r_seen_busy <= 1'b0;
      r_wd        <= '0;
      r_ops       <= '0;
    end else begin
      if (w_load) r_ops <= r_ops + 1'b1;
      if (r_state inside {GAP, SEND_A, SEND_B, WAIT} && !fp_done) r_seen_busy <= 1'b1;
      case (r_state)
        IDLE: if (w_fire) begin
          r_a         <= op_a;
          r_b         <= op_b;
          r_fp_start  <= 1'b1;
          r_fp_bus    <= op_a;
          r_seen_busy <= 1'b0;
          r_state     <= START;
        end
        START: begin
          r_fp_start <= 1'b0;
          r_fp_bus   <= r_a;
          r_state    <= GAP;
        end
        GAP: r_state <= SEND_A;
        SEND_A: begin
          r_fp_bus <= r_b;
          r_wd     <= '0;
          r_state  <= SEND_B;
        end
        // watchdog reads 0 during SEND_B and counts every cycle after it
        SEND_B: begin
          r_fp_bus <= '0;
          r_wd     <= r_wd + 1'b1;
          r_state  <= WAIT;
        end
        WAIT: begin
          r_wd <= r_wd + 1'b1;
          if (w_load) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  fpmult_res_buf #(.W(DATA_W + 1)) u_res_buf (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_data (w_res),
    .i_ready(res_ready),
    .o_valid(res_valid),
    .o_data (w_buf)
  );
  assign res_err  = w_buf[DATA_W];
  assign res_data = w_buf[DATA_W-1:0];
  assign fp_start = r_fp_start;
  assign fp_bus   = r_fp_bus;
  assign busy     = r_state != IDLE;
  assign ops_done = r_ops;
endmodule

// File: tb/tb_fpmult_host.sv
// tb_fpmult_host: directed vectors against a behavioural multiplier with a result scoreboard
module tb_fpmult_host;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        fp_start;
  logic [31:0] fp_bus;
  logic        fp_done = 1'b1;
  logic [31:0] fp_res = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_data;
  logic        res_err;
  logic        busy;
  logic [15:0] ops_done;
  int checks = 0;
  int failures = 0;
  logic [32:0] sb[$];
  bit hang = 1'b0;
  always #5 clk = ~clk;
  fpmult_host #(.DATA_W(32), .TIMEOUT(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .fp_start(fp_start), .fp_bus(fp_bus), .fp_done(fp_done), .fp_res(fp_res),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .busy(busy), .ops_done(ops_done)
  );
  function automatic logic [31:0] mul(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40000000, 32'h40400000}: return 32'h40C00000;
      {32'h3FC00000, 32'h3FC00000}: return 32'h40100000;
      {32'h3F800000, 32'hC0000000}: return 32'hC0000000;
      {32'h7F800000, 32'h00000000}: return 32'hFFC00000;
      {32'h3F800000, 32'h3F800000}: return 32'h3F800000;
      {32'h40000000, 32'h40000000}: return 32'h40800000;
      {32'h40400000, 32'h40400000}: return 32'h41100000;
      default: return 32'hDEADBEEF;
    endcase
  endfunction
  typedef enum {M_IDLE, M_INIT, M_A, M_B, M_CALC} m_t;
  m_t m_st = M_IDLE;
  logic [31:0] m_a = '0;
  logic [31:0] m_p = '0;
  int m_cnt = 0;
  always @(posedge clk) begin
    case (m_st)
      M_IDLE: if (fp_start) begin m_st <= M_INIT; fp_done <= 1'b0; end
      M_INIT: if (!fp_start) m_st <= M_A;
      M_A: begin m_a <= fp_bus; m_st <= M_B; end
      M_B: begin
        m_p <= mul(m_a, fp_bus);
        m_cnt <= (m_a == 32'h7F800000 && fp_bus == 32'h0) ? 1 : 5;
        m_st <= M_CALC;
      end
      M_CALC: if (!hang) begin
        if (m_cnt == 1) begin fp_done <= 1'b1; fp_res <= m_p; m_st <= M_IDLE; end
        else m_cnt <= m_cnt - 1;
      end
      default: m_st <= M_IDLE;
    endcase
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      if (sb.size() == 0) chk("unexpected result", {31'b0, res_valid}, 32'h0);
      else begin
        logic [32:0] e;
        e = sb.pop_front();
        chk("res_data", res_data, e[31:0]);
        chk("res_err", {31'b0, res_err}, {31'b0, e[32]});
      end
    end
  end
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [32:0] exp);
    int n;
    sb.push_back(exp);
    op_a = a;
    op_b = b;
    op_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!op_ready && n < 300);
    if (!op_ready) begin
      chk("handshake timeout", 32'h0, 32'h1);
      op_valid = 1'b0;
      void'(sb.pop_back());
      return;
    end
    @(posedge clk); #1 op_valid = 1'b0;
    @(negedge clk);
    chk("S fp_start", {31'b0, fp_start}, 32'h1);
    chk("S fp_bus", fp_bus, a);
    chk("S op_ready", {31'b0, op_ready}, 32'h0);
    @(negedge clk);
    chk("S+1 fp_start", {31'b0, fp_start}, 32'h0);
    chk("S+1 fp_bus", fp_bus, a);
    @(negedge clk);
    chk("S+2 fp_start", {31'b0, fp_start}, 32'h0);
    chk("S+2 fp_bus", fp_bus, a);
    @(negedge clk);
    chk("S+3 fp_start", {31'b0, fp_start}, 32'h0);
    chk("S+3 fp_bus", fp_bus, b);
    chk("S+3 op_ready", {31'b0, op_ready}, 32'h0);
  endtask
  task automatic wait_empty();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      chk("result timeout", sb.size(), 32'h0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask
  initial begin
    #300000;
    $display("FAIL global time limit checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'h0);
    chk("reset fp_start", {31'b0, fp_start}, 32'h0);
    chk("reset fp_bus", fp_bus, 32'h0);
    chk("reset res_valid", {31'b0, res_valid}, 32'h0);
    chk("reset ops_done", {16'b0, ops_done}, 32'h0);
    chk("reset op_ready", {31'b0, op_ready}, 32'h1);
    @(posedge clk); #1;
    issue(32'h40000000, 32'h40400000, {1'b0, 32'h40C00000});
    wait_empty();
    chk("ops_done t1", {16'b0, ops_done}, 32'd1);
    issue(32'h3FC00000, 32'h3FC00000, {1'b0, 32'h40100000});
    @(posedge clk); #1;
    issue(32'h3F800000, 32'hC0000000, {1'b0, 32'hC0000000});
    wait_empty();
    chk("ops_done t2", {16'b0, ops_done}, 32'd3);
    issue(32'h7F800000, 32'h00000000, {1'b0, 32'hFFC00000});
    wait_empty();
    chk("ops_done t3", {16'b0, ops_done}, 32'd4);
    hang = 1'b1;
    issue(32'h3F800000, 32'h3F800000, {1'b1, 32'h7FC00000});
    n = 0;
    while (!res_valid && n < 200) begin @(negedge clk); n++; end
    chk("timeout latency", n, 32'd64);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ops_done t4", {16'b0, ops_done}, 32'd5);
    chk("idle busy", {31'b0, busy}, 32'h0);
    chk("op_ready blocked by fp_done", {31'b0, op_ready}, 32'h0);
    hang = 1'b0;
    @(posedge clk); #1 res_ready = 1'b0;
    issue(32'h40000000, 32'h40000000, {1'b0, 32'h40800000});
    n = 0;
    while (!res_valid && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    sb.push_back({1'b0, 32'h41100000});
    op_a = 32'h40400000;
    op_b = 32'h40400000;
    op_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("held res_data", res_data, 32'h40800000);
      chk("held op_ready", {31'b0, op_ready}, 32'h0);
    end
    chk("held res_valid", {31'b0, res_valid}, 32'h1);
    @(posedge clk); #1 res_ready = 1'b1;
    @(negedge clk);
    chk("drain op_ready", {31'b0, op_ready}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post-drain res_valid", {31'b0, res_valid}, 32'h0);
    chk("post-drain op_ready", {31'b0, op_ready}, 32'h1);
    @(posedge clk); #1 op_valid = 1'b0;
    wait_empty();
    chk("ops_done t5", {16'b0, ops_done}, 32'd7);
    issue(32'h40000000, 32'h40400000, {1'b0, 32'h40C00000});
    @(posedge clk); #1 rst = 1'b1;
    void'(sb.pop_back());
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst busy", {31'b0, busy}, 32'h0);
    chk("rst fp_start", {31'b0, fp_start}, 32'h0);
    chk("rst fp_bus", fp_bus, 32'h0);
    chk("rst res_valid", {31'b0, res_valid}, 32'h0);
    chk("rst ops_done", {16'b0, ops_done}, 32'h0);
    @(posedge clk); #1;
    issue(32'h40000000, 32'h40400000, {1'b0, 32'h40C00000});
    wait_empty();
    chk("ops_done t6", {16'b0, ops_done}, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
